// File: rtl/vscale_mem_arbiter_pkg.sv
// vscale_mem_arbiter_pkg
//   Shared constants and types for the vscale memory arbiter.
//   - Bus-level codes: HTRANS_IDLE/NONSEQ, HSIZE byte/half/word, HRESP_ERROR.
//   - Data-phase owner encoding (2 bits): OWNER_NONE / OWNER_I / OWNER_D.
//   - addr_misaligned(): alignment test used when VSCALE_ARB_MISALIGN_EN is defined.
package vscale_mem_arbiter_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_ERROR = 1'b1;

  localparam int OWNER_W = 2;

  typedef enum logic [OWNER_W-1:0] {
    OWNER_NONE = 2'd0,
    OWNER_I    = 2'd1,
    OWNER_D    = 2'd2
  } owner_e;

  // Low three address bits are enough for every size code up to 8 bytes.
  function automatic logic addr_misaligned(input logic [2:0] addr_lo,
                                           input logic [2:0] size);
    case (size[1:0])
      HSIZE_BYTE[1:0]: return 1'b0;
      HSIZE_HALF[1:0]: return addr_lo[0];
      HSIZE_WORD[1:0]: return |addr_lo[1:0];
      default:         return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/vscale_arb_port_skid.sv
// vscale_arb_port_skid
//   Per-port replay holder. A request that cannot be issued this cycle (lost
//   arbitration or bus stalled) is captured and presented again until granted.
//   While a replay is pending, the live request on the port is ignored.
// Ports
//   clk, reset              clock, synchronous active-high reset
//   req/addr/wen/size       live address-phase request from the core
//   grant                   candidate issued this cycle
//   pend                    replay register holds a request
//   cand_*                  candidate seen by the arbiter (replay if pend, else live)
module vscale_arb_port_skid #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic [XLEN-1:0] addr,
  input  logic            wen,
  input  logic [2:0]      size,
  input  logic            grant,
  output logic            pend,
  output logic            cand_valid,
  output logic [XLEN-1:0] cand_addr,
  output logic            cand_wen,
  output logic [2:0]      cand_size
);

  logic [XLEN-1:0] rp_addr;
  logic            rp_wen;
  logic [2:0]      rp_size;

  assign cand_valid = pend | req;
  assign cand_addr  = pend ? rp_addr : addr;
  assign cand_wen   = pend ? rp_wen  : wen;
  assign cand_size  = pend ? rp_size : size;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= 1'b0;
    end else if (grant) begin
      pend <= 1'b0;
    end else if (cand_valid) begin
      pend <= 1'b1;
    end
  end

  // Re-capturing the replay value onto itself while pending is harmless and
  // keeps the load enable simple.
  always_ff @(posedge clk) begin
    if (cand_valid && !grant) begin
      rp_addr <= cand_addr;
      rp_wen  <= cand_wen;
      rp_size <= cand_size;
    end
  end

endmodule

// File: rtl/vscale_mem_arbiter.sv
// vscale_mem_arbiter
//   Shares one pipelined (address/data phase) bus master port between the
//   instruction-fetch port (imem) and the data port (dmem). dmem has priority;
//   after D_STREAK_MAX consecutive dmem grants with imem waiting, imem wins once.
//   Optional feature macro: VSCALE_ARB_MISALIGN_EN -- misaligned candidates win
//   arbitration but are never put on the bus; they report badmem_e next cycle.
// Ports
//   clk, reset                         clock, synchronous active-high reset
//   imem_req/addr                      fetch address phase
//   imem_rdata/wait/badmem_e           fetch data phase results
//   dmem_en/wen/size/addr/wdata        data access request (wdata in data phase)
//   dmem_rdata/wait/badmem_e           data access results
//   haddr/hwrite/hsize/htrans/hwdata   bus master outputs
//   hrdata/hready/hresp                bus responses
module vscale_mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int D_STREAK_MAX = 4,
  parameter int STREAK_W     = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            imem_req,
  input  logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] imem_rdata,
  output logic            imem_wait,
  output logic            imem_badmem_e,
  input  logic            dmem_en,
  input  logic            dmem_wen,
  input  logic [2:0]      dmem_size,
  input  logic [XLEN-1:0] dmem_addr,
  input  logic [XLEN-1:0] dmem_wdata,
  output logic [XLEN-1:0] dmem_rdata,
  output logic            dmem_wait,
  output logic            dmem_badmem_e,
  output logic [XLEN-1:0] haddr,
  output logic            hwrite,
  output logic [2:0]      hsize,
  output logic [1:0]      htrans,
  output logic [XLEN-1:0] hwdata,
  input  logic [XLEN-1:0] hrdata,
  input  logic            hready,
  input  logic            hresp
);

  import vscale_mem_arbiter_pkg::*;

  logic            pend_i, pend_d;
  logic            ci_valid, cd_valid;
  logic [XLEN-1:0] ci_addr, cd_addr;
  logic            ci_wen, cd_wen;
  logic [2:0]      ci_size, cd_size;

  logic            issue_ok, streak_full;
  logic            grant_i, grant_d, grant_any;
  logic [XLEN-1:0] win_addr;
  logic            win_wen;
  logic [2:0]      win_size;
  logic            win_bad;

  owner_e                dp_owner;
  logic                  dp_fault;
  logic                  dp_write;
  logic [STREAK_W-1:0]   streak;
  logic                  owner_i, owner_d;

  vscale_arb_port_skid #(.XLEN(XLEN)) u_skid_i (
    .clk        (clk),
    .reset      (reset),
    .req        (imem_req),
    .addr       (imem_addr),
    .wen        (1'b0),
    .size       (HSIZE_WORD),
    .grant      (grant_i),
    .pend       (pend_i),
    .cand_valid (ci_valid),
    .cand_addr  (ci_addr),
    .cand_wen   (ci_wen),
    .cand_size  (ci_size)
  );

  vscale_arb_port_skid #(.XLEN(XLEN)) u_skid_d (
    .clk        (clk),
    .reset      (reset),
    .req        (dmem_en),
    .addr       (dmem_addr),
    .wen        (dmem_wen),
    .size       (dmem_size),
    .grant      (grant_d),
    .pend       (pend_d),
    .cand_valid (cd_valid),
    .cand_addr  (cd_addr),
    .cand_wen   (cd_wen),
    .cand_size  (cd_size)
  );

  // Nothing issues while reset is asserted so the bus stays IDLE.
  assign issue_ok    = hready & ~reset;
  assign streak_full = (streak == STREAK_W'(D_STREAK_MAX));

  assign grant_i   = issue_ok & ci_valid & (~cd_valid | streak_full);
  assign grant_d   = issue_ok & cd_valid & ~grant_i;
  assign grant_any = grant_i | grant_d;

  assign win_addr = grant_i ? ci_addr : cd_addr;
  assign win_wen  = grant_i ? ci_wen  : cd_wen;
  assign win_size = grant_i ? ci_size : cd_size;

`ifdef VSCALE_ARB_MISALIGN_EN
  assign win_bad = addr_misaligned(win_addr[2:0], win_size);
`else
  assign win_bad = 1'b0;
`endif

  assign haddr  = win_addr;
  assign hwrite = win_wen;
  assign hsize  = win_size;
  assign htrans = (grant_any && !win_bad) ? HTRANS_NONSEQ : HTRANS_IDLE;

  always_ff @(posedge clk) begin
    if (reset) begin
      dp_owner <= OWNER_NONE;
      dp_fault <= 1'b0;
      dp_write <= 1'b0;
      streak   <= '0;
    end else begin
      // A faulted data phase never reached the bus, so it retires without hready.
      if (hready || dp_fault) begin
        dp_owner <= grant_i ? OWNER_I : (grant_d ? OWNER_D : OWNER_NONE);
        dp_fault <= grant_any & win_bad;
        dp_write <= grant_d & cd_wen;
      end
      if (grant_i) begin
        streak <= '0;
      end else if (grant_d) begin
        if (!ci_valid)
          streak <= '0;
        else if (!streak_full)
          streak <= streak + 1'b1;
      end
    end
  end

  assign owner_i = (dp_owner == OWNER_I);
  assign owner_d = (dp_owner == OWNER_D);

  assign imem_wait = ~reset & (pend_i | (owner_i & ~hready & ~dp_fault));
  assign dmem_wait = ~reset & (pend_d | (owner_d & ~hready & ~dp_fault));

  // hresp during a stalled cycle is ignored; only the completing cycle reports.
  assign imem_badmem_e = ~reset & owner_i &
                         (dp_fault | (hready & (hresp == HRESP_ERROR)));
  assign dmem_badmem_e = ~reset & owner_d &
                         (dp_fault | (hready & (hresp == HRESP_ERROR)));

  assign imem_rdata = hrdata;
  assign dmem_rdata = hrdata;
  assign hwdata     = (owner_d && dp_write) ? dmem_wdata : '0;

endmodule
